// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch datapath for a multicycle RV32I core. Holds the program counter,
//   issues word reads to instruction memory over a ready handshake, buffers
//   the returned word and loads the instruction register on LoadIR.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   PCWrite               : update PC and launch a fetch of the current PC
//   LoadIR                : load IR from the fetched word (buffer or bypass)
//   PCSource              : 0 -> next PC = PC+4, 1 -> next PC = branch_target
//   branch_target         : redirect address, sampled with PCWrite
//   mem_addr/mem_rd       : word read request, held until mem_ready
//   mem_rdata/mem_ready   : read data and single-cycle completion
//   pc, fetch_pc, instr   : current PC, address of IR word, instruction reg
//   opcode..funct7        : RV32I fields sliced from instr
//   fetch_busy            : fetch outstanding, LoadIR not yet satisfiable
//   fetch_err             : sticky fault (timeout or misaligned target)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        LoadIR,
   input  logic        PCSource,
   input  logic [31:0] branch_target,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] fetch_pc,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic        fetch_busy,
   output logic        fetch_err
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] addr_r;       // address A of the word being / last fetched
   logic [31:0] buf_r;
   logic        buf_valid_r;
   logic [31:0] instr_r;
   logic [31:0] fetch_pc_r;
   logic [31:0] mem_addr_r;
   logic        mem_rd_r;
   logic        busy_r;
   logic        err_r;
   logic [7:0]  cnt_r;

   logic [31:0] pc_next_s;
   logic        misaligned_s;

   // Next-PC selection and redirect alignment check
   always_comb begin
      pc_next_s    = 32'h0000_0000;
      misaligned_s = 1'b0;
      if (PCSource) begin
         pc_next_s    = branch_target;
         misaligned_s = (branch_target[1:0] != 2'b00);
      end else begin
         pc_next_s    = pc_r + 32'd4;   // wraps mod 2^32
         misaligned_s = 1'b0;
      end
   end

   // Fetch FSM, PC/IR datapath and registered handshake outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         addr_r      <= RESET_PC;
         buf_r       <= 32'h0000_0000;
         buf_valid_r <= 1'b0;
         instr_r     <= NOP_INSTR;
         fetch_pc_r  <= RESET_PC;
         mem_addr_r  <= 32'h0000_0000;
         mem_rd_r    <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         cnt_r       <= 8'd0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               // IR load uses the old buffer/address even if a new fetch
               // launches on the same edge (non-blocking ordering).
               if (LoadIR && buf_valid_r) begin
                  instr_r    <= buf_r;
                  fetch_pc_r <= addr_r;
               end
               if (PCWrite) begin
                  if (misaligned_s) begin
                     err_r   <= 1'b1;
                     state_r <= ERR;
                  end else begin
                     addr_r      <= pc_r;
                     mem_addr_r  <= pc_r;
                     pc_r        <= pc_next_s;
                     buf_valid_r <= 1'b0;
                     mem_rd_r    <= 1'b1;
                     busy_r      <= 1'b1;
                     cnt_r       <= 8'd0;
                     state_r     <= REQ;
                  end
               end
            end
            REQ, WAIT: begin
               // PCWrite is deliberately ignored while a request is open.
               if (mem_ready) begin
                  buf_r       <= mem_rdata;
                  buf_valid_r <= 1'b1;
                  mem_rd_r    <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= DONE;
                  if (LoadIR) begin
                     instr_r    <= mem_rdata;   // bypass the buffer
                     fetch_pc_r <= addr_r;
                  end
               end else if (state_r == REQ) begin
                  cnt_r   <= 8'd1;
                  state_r <= WAIT;
               end else if (cnt_r >= TIMEOUT_C) begin
                  err_r    <= 1'b1;
                  mem_rd_r <= 1'b0;
                  busy_r   <= 1'b0;
                  state_r  <= ERR;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ERR: begin
               // Sticky until reset; all strobes ignored.
               mem_rd_r <= 1'b0;
               busy_r   <= 1'b0;
               err_r    <= 1'b1;
            end
            default: begin
               mem_rd_r <= 1'b0;
               busy_r   <= 1'b0;
               err_r    <= 1'b1;
               state_r  <= ERR;
            end
         endcase
      end
   end

   assign pc         = pc_r;
   assign fetch_pc   = fetch_pc_r;
   assign instr      = instr_r;
   assign mem_addr   = mem_addr_r;
   assign mem_rd     = mem_rd_r;
   assign fetch_busy = busy_r;
   assign fetch_err  = err_r;

   assign opcode = instr_r[6:0];
   assign rd     = instr_r[11:7];
   assign funct3 = instr_r[14:12];
   assign rs1    = instr_r[19:15];
   assign rs2    = instr_r[24:20];
   assign funct7 = instr_r[31:25];

endmodule
